pll_freq_monitor: RTL and testbench

//  Receiving end of the rPLL clock path: measures a PLL-generated clock against the 27 MHz board clock.

---
 rtl/pll_mon_pkg.sv | 30 +++
 rtl/async_edge_sync.sv | 41 ++++
 rtl/pll_freq_monitor.sv | 161 ++++++++++++++++
 tb/tb_pll_freq_monitor.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_mon_pkg.sv
// -----------------------------------------------------------------------------
// pll_mon_pkg
//   Shared definitions for the PLL frequency monitor and related clock-checking
//   blocks: measurement FSM state encoding, board-clock constants and a
//   constant-evaluable ceil(log2) used to size counters from parameters.
// -----------------------------------------------------------------------------
package pll_mon_pkg;

  // Measurement sequence: idle, one-cycle arm, gate window, one-cycle evaluate.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_GATE = 2'd2,
    ST_EVAL = 2'd3
  } mon_state_t;

  localparam int unsigned CLK_HZ   = 27_000_000;
  localparam int unsigned GATE_1MS = 27000;

  // Bits needed to hold values 0..value-1 (never less than 1 bit).
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned bits;
    bits = 0;
    while ((64'd1 << bits) < 64'(value)) begin
      bits++;
    end
    return (bits == 0) ? 1 : bits;
  endfunction

endpackage

// File: rtl/async_edge_sync.sv
// -----------------------------------------------------------------------------
// async_edge_sync
//   Brings an asynchronous signal into the clk domain through a two-flop
//   synchronizer and produces a one-cycle pulse on each synchronized rising
//   edge. Detection latency is 2-3 clk cycles. The input must toggle slower
//   than clk/2 or edges are lost.
// Ports
//   clk      in  system clock, rising edge
//   rst_n    in  synchronous reset, active-low
//   i_async  in  asynchronous input
//   o_rise   out one-cycle pulse per synchronized rising edge
// -----------------------------------------------------------------------------
module async_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_rise
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  // NOTE: reset is sampled on the clock edge (synchronous), so rst_n is not
  // in the sensitivity list; state uses <= so all flops update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_async;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // r_s3 is the history flop; a rise is "high now, low one cycle ago".
  assign o_rise = r_s2 & ~r_s3;

endmodule

// File: rtl/pll_freq_monitor.sv
// -----------------------------------------------------------------------------
// pll_freq_monitor
//   Measures a PLL-generated clock against the board clock by counting its
//   rising edges over a fixed gate window. Each completed window reports the
//   count, an overflow flag and a range check. After GOOD_WINDOWS consecutive
//   in-range windows freq_ok asserts and is then used as "clock trusted".
// Ports
//   clk         in   system clock, all logic on rising edge
//   rst_n       in   synchronous reset, active-low
//   meas_clk    in   clock under test, asynchronous to clk (< clk/2)
//   enable      in   1 = run measurement windows back to back
//   edge_count  out  edge count of the last completed window
//   meas_valid  out  one-cycle pulse when the window results update
//   in_range    out  last window within EXPECT_EDGES +/- TOL_EDGES
//   overflow    out  last window saturated the edge counter
//   freq_ok     out  GOOD_WINDOWS consecutive in-range windows seen
// -----------------------------------------------------------------------------
module pll_freq_monitor
  import pll_mon_pkg::*;
#(
  parameter int unsigned GATE_CYCLES  = GATE_1MS,
  parameter int unsigned EXPECT_EDGES = 6000,
  parameter int unsigned TOL_EDGES    = 30,
  parameter int unsigned GOOD_WINDOWS = 4,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             meas_clk,
  input  logic             enable,
  output logic [CNT_W-1:0] edge_count,
  output logic             meas_valid,
  output logic             in_range,
  output logic             overflow,
  output logic             freq_ok
);

  localparam int unsigned GATE_W = clog2(GATE_CYCLES + 1);
  localparam int unsigned RUN_W  = clog2(GOOD_WINDOWS + 1);

  localparam logic [GATE_W-1:0]       GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]        CNT_MAX   = '1;
  localparam logic signed [CNT_W:0]   EXPECT_S  = (CNT_W + 1)'(EXPECT_EDGES);
  localparam logic signed [CNT_W:0]   TOL_S     = (CNT_W + 1)'(TOL_EDGES);
  localparam logic [RUN_W-1:0]        RUN_GOAL  = RUN_W'(GOOD_WINDOWS);

  mon_state_t             r_state;
  mon_state_t             w_next_state;
  logic [GATE_W-1:0]      r_gate_cnt;
  logic [CNT_W-1:0]       r_edge_cnt;
  logic                   r_ovf;
  logic [RUN_W-1:0]       r_run;
  logic [CNT_W-1:0]       r_edge_count;
  logic                   r_meas_valid;
  logic                   r_in_range;
  logic                   r_overflow;
  logic                   r_freq_ok;

  logic                   w_rise;
  logic                   w_gate_done;
  logic signed [CNT_W:0]  w_diff;
  logic signed [CNT_W:0]  w_abs;
  logic                   w_in_range;
  logic [RUN_W-1:0]       w_run_next;

  async_edge_sync u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (meas_clk),
    .o_rise  (w_rise)
  );

  assign w_gate_done = (r_gate_cnt == GATE_LAST);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default first so every path assigns w_next_state (no latch).
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE: if (enable) w_next_state = ST_ARM;
      ST_ARM:  w_next_state = ST_GATE;
      ST_GATE: begin
        if (!enable)          w_next_state = ST_IDLE;
        else if (w_gate_done) w_next_state = ST_EVAL;
      end
      ST_EVAL: w_next_state = enable ? ST_ARM : ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Range check and good-window run, evaluated on the finished window.
  // One extra bit keeps the signed difference from wrapping.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_diff     = $signed({1'b0, r_edge_cnt}) - EXPECT_S;
    w_abs      = w_diff[CNT_W] ? -w_diff : w_diff;
    w_in_range = !r_ovf && (w_abs <= TOL_S);
    if (!w_in_range)           w_run_next = '0;
    else if (r_run == RUN_GOAL) w_run_next = r_run;
    else                       w_run_next = r_run + 1'b1;
  end

  // ---------------------------------------------------------------------------
  // State, counters and reported results
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_gate_cnt   <= '0;
      r_edge_cnt   <= '0;
      r_ovf        <= 1'b0;
      r_run        <= '0;
      r_edge_count <= '0;
      r_meas_valid <= 1'b0;
      r_in_range   <= 1'b0;
      r_overflow   <= 1'b0;
      r_freq_ok    <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_meas_valid <= 1'b0;
      case (r_state)
        ST_ARM: begin
          r_gate_cnt <= '0;
          r_edge_cnt <= '0;
          r_ovf      <= 1'b0;
        end
        ST_GATE: begin
          r_gate_cnt <= r_gate_cnt + 1'b1;
          if (w_rise) begin
            if (r_edge_cnt == CNT_MAX) r_ovf      <= 1'b1;
            else                       r_edge_cnt <= r_edge_cnt + 1'b1;
          end
          // Aborted window: trust is withdrawn, last results are kept.
          if (!enable) begin
            r_run     <= '0;
            r_freq_ok <= 1'b0;
          end
        end
        ST_EVAL: begin
          r_edge_count <= r_edge_cnt;
          r_in_range   <= w_in_range;
          r_overflow   <= r_ovf;
          r_meas_valid <= 1'b1;
          r_run        <= w_run_next;
          r_freq_ok    <= (w_run_next == RUN_GOAL);
        end
        default: ;
      endcase
    end
  end

  assign edge_count = r_edge_count;
  assign meas_valid = r_meas_valid;
  assign in_range   = r_in_range;
  assign overflow   = r_overflow;
  assign freq_ok    = r_freq_ok;

endmodule

// File: tb/tb_pll_freq_monitor.sv
// -----------------------------------------------------------------------------
// tb_pll_freq_monitor
//   Scoreboard bench. The main DUT uses a scaled-down window (1350 cycles,
//   300 nominal edges) so many windows fit in a short run; a second instance
//   with an 8-bit counter is fed clk/3 so every window saturates.
//   The stimulus process chooses the meas_clk rate for each window and queues
//   the expected result; a monitor pops and compares on every meas_valid.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pll_freq_monitor;

  localparam real TCLK   = 37.0;
  localparam int  GATE   = 1350;
  localparam int  EXPECT = 300;
  localparam int  TOL    = 3;
  localparam int  GOOD   = 4;
  localparam int  CNT_W  = 16;
  localparam int  SLACK  = 2;
  localparam int  LIMIT  = GATE + 10;

  localparam int  GATE2  = 1000;
  localparam int  CNT_W2 = 8;
  localparam int  N2     = GATE2 / 3;
  localparam int  SAT2   = (1 << CNT_W2) - 1;
  localparam int  EXP2   = (N2 > SAT2) ? SAT2 : N2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              meas_clk;
  logic              enable;
  logic [CNT_W-1:0]  edge_count;
  logic              meas_valid, in_range, overflow, freq_ok;

  logic              meas_clk2;
  logic              enable2;
  logic [CNT_W2-1:0] edge_count2;
  logic              meas_valid2, in_range2, overflow2, freq_ok2;

  pll_freq_monitor #(
    .GATE_CYCLES(GATE), .EXPECT_EDGES(EXPECT), .TOL_EDGES(TOL),
    .GOOD_WINDOWS(GOOD), .CNT_W(CNT_W)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .meas_clk(meas_clk), .enable(enable),
    .edge_count(edge_count), .meas_valid(meas_valid), .in_range(in_range),
    .overflow(overflow), .freq_ok(freq_ok)
  );

  pll_freq_monitor #(
    .GATE_CYCLES(GATE2), .EXPECT_EDGES(200), .TOL_EDGES(10),
    .GOOD_WINDOWS(GOOD), .CNT_W(CNT_W2)
  ) u_ovf (
    .clk(clk), .rst_n(rst_n), .meas_clk(meas_clk2), .enable(enable2),
    .edge_count(edge_count2), .meas_valid(meas_valid2), .in_range(in_range2),
    .overflow(overflow2), .freq_ok(freq_ok2)
  );

  always #(TCLK / 2.0) clk = ~clk;

  // clk/3, offset so its edges never coincide with clk edges.
  initial begin
    meas_clk2 = 1'b0;
    #5;
    forever #(TCLK * 1.5) meas_clk2 = ~meas_clk2;
  end

  // Clock under test: free-running at a chosen half period, or stuck.
  typedef enum {M_RUN, M_LOW, M_HIGH} mode_t;
  mode_t meas_mode = M_LOW;
  real   meas_half = 100.0;

  initial begin
    meas_clk = 1'b0;
    forever begin
      if (meas_mode == M_RUN) begin
        #(meas_half) meas_clk = ~meas_clk;
      end else begin
        meas_clk = (meas_mode == M_HIGH);
        @(meas_mode);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model and scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    int lo;
    int hi;
    bit in_rng;
    bit ok;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   consec   = 0;    // consecutive in-range windows since last break
  bit   last_in  = 1'b0; // in_range of the last reported window
  int   last_lo  = 0;
  int   last_hi  = 0;
  int   seen2    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d..%0d", name, act, lo, hi);
    end
  endtask

  // Set meas_clk for the window now starting and queue its expected result.
  // A window of exactly GATE clk cycles sees n = GATE*Tclk/Tmeas edges,
  // give or take phase and the rate switch at the window start.
  task automatic start_window(input int n, input mode_t m);
    exp_t e;
    bit   same_stuck;
    int   nom;
    same_stuck = (m != M_RUN) && (m == meas_mode);
    if (m == M_RUN) meas_half = TCLK * GATE / (2.0 * n);
    meas_mode = m;
    nom       = (m == M_RUN) ? n : 0;
    e.lo      = same_stuck ? nom : ((nom > SLACK) ? nom - SLACK : 0);
    e.hi      = same_stuck ? nom : nom + SLACK;
    e.in_rng  = (nom >= EXPECT - TOL) && (nom <= EXPECT + TOL);
    consec    = e.in_rng ? consec + 1 : 0;
    e.ok      = (consec >= GOOD);
    sb_q.push_back(e);
  endtask

  // Monitor for the main DUT.
  always @(negedge clk) begin
    if (meas_valid) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_meas_valid: actual=1 required=0 edge_count=%0d", edge_count);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_range("edge_count", int'(edge_count), e.lo, e.hi);
        check("in_range", 32'(in_range), 32'(e.in_rng));
        check("overflow", 32'(overflow), 32'd0);
        check("freq_ok", 32'(freq_ok), 32'(e.ok));
        last_in = e.in_rng;
        last_lo = e.lo;
        last_hi = e.hi;
      end
    end
  end

  // Monitor for the saturating instance: clk/3 over GATE2 cycles is N2 edges,
  // well past the 8-bit maximum.
  always @(negedge clk) begin
    if (meas_valid2) begin
      seen2++;
      check("ovf_edge_count", 32'(edge_count2), 32'(EXP2));
      check("ovf_overflow", 32'(overflow2), 32'(N2 > SAT2));
      check("ovf_in_range", 32'(in_range2), 32'd0);
      check("ovf_freq_ok", 32'(freq_ok2), 32'd0);
    end
  end

  // Returns the number of negedges until meas_valid is seen (bounded).
  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!meas_valid && n < LIMIT);
    check("meas_valid_arrived", 32'(meas_valid), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_edge_count"}, 32'(edge_count), 32'd0);
    check({tag, "_meas_valid"}, 32'(meas_valid), 32'd0);
    check({tag, "_in_range"},   32'(in_range),   32'd0);
    check({tag, "_overflow"},   32'(overflow),   32'd0);
    check({tag, "_freq_ok"},    32'(freq_ok),    32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int n;
    int r;
    int cnt;
    int out_vals[4];
    out_vals = '{250, 290, 306, 320};

    rst_n   = 1'b0;
    enable  = 1'b0;
    enable2 = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n   = 1'b1;
    enable2 = 1'b1;

    // Lock at nominal rate; freq_ok must come up on the 4th window.
    start_window(300, M_RUN);
    enable = 1'b1;
    wait_valid(n);
    check("first_latency", 32'(n), 32'(GATE + 3));
    repeat (5) begin
      start_window(299 + $urandom_range(0, 2), M_RUN);
      wait_valid(n);
      check("window_period", 32'(n), 32'(GATE + 2));
    end

    // Slow clock after lock: trust drops in that window's result.
    start_window(250, M_RUN);
    wait_valid(n);

    // Stuck low: second window sees no edges at all.
    repeat (2) begin
      start_window(0, M_LOW);
      wait_valid(n);
      check("stuck_period", 32'(n), 32'(GATE + 2));
    end

    // Random mix of good, bad and stuck windows.
    repeat (8) begin
      r = $urandom_range(0, 9);
      if (r <= 5)      start_window(299 + $urandom_range(0, 2), M_RUN);
      else if (r == 6) start_window(0, M_LOW);
      else if (r == 7) start_window(0, M_HIGH);
      else             start_window(out_vals[$urandom_range(0, 3)], M_RUN);
      wait_valid(n);
      check("window_period", 32'(n), 32'(GATE + 2));
    end

    // Re-lock, then abort a window part way through.
    repeat (4) begin
      start_window(300, M_RUN);
      wait_valid(n);
    end
    start_window(300, M_RUN);
    repeat (500) @(negedge clk);
    enable = 1'b0;
    sb_q.delete();
    consec = 0;
    @(negedge clk);
    check("abort_freq_ok", 32'(freq_ok), 32'd0);
    check("abort_in_range_held", 32'(in_range), 32'(last_in));
    check_range("abort_edge_count_held", int'(edge_count), last_lo, last_hi);
    cnt = 0;
    repeat (LIMIT) begin
      @(negedge clk);
      if (meas_valid) cnt++;
    end
    check("no_valid_while_disabled", 32'(cnt), 32'd0);

    start_window(300, M_RUN);
    enable = 1'b1;
    wait_valid(n);
    check("reenable_latency", 32'(n), 32'(GATE + 3));

    // One-cycle reset part way through a window.
    start_window(300, M_RUN);
    repeat (600) @(negedge clk);
    rst_n = 1'b0;
    sb_q.delete();
    consec = 0;
    @(negedge clk);
    check_all_zero("midreset");
    rst_n = 1'b1;
    start_window(300, M_RUN);
    wait_valid(n);
    check("restart_latency", 32'(n), 32'(GATE + 3));

    enable = 1'b0;
    repeat (5) @(negedge clk);
    check("ovf_windows_seen", 32'(seen2 > 0), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
